// File: rtl/sopc_intc_if.sv
// rtl/sopc_intc_if.sv - data-memory bus bundle between the core and sopc_intc
//
// Signals: ce_i (access strobe), we_i (1 = write), sel_i (byte lanes),
// addr_i (byte address), wdata_i (write data), rdata_o (registered read data).
// Modports: master = core side, slave = interrupt controller side.
interface sopc_intc_if #(
    parameter int ADDR_WIDTH = 6
) ();
    logic                  ce_i;
    logic                  we_i;
    logic [3:0]            sel_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [31:0]           wdata_i;
    logic [31:0]           rdata_o;

    modport master (
        output ce_i, we_i, sel_i, addr_i, wdata_i,
        input  rdata_o
    );

    modport slave (
        input  ce_i, we_i, sel_i, addr_i, wdata_i,
        output rdata_o
    );
endinterface

// File: rtl/sopc_intc.sv
// rtl/sopc_intc.sv - memory-mapped maskable interrupt controller with per-source routing
//
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset
//   src_i  NUM_SRC raw interrupt requests, active high
//   bus    sopc_intc_if.slave data-memory bus (ce/we/sel/addr/wdata in, rdata out)
//   int_o  NUM_OUT registered interrupt lines to the core
// Registers (word offsets): 0x00 PENDING, 0x04 MASK, 0x08 MODE, 0x0C CLAIM,
//   0x10..0x1C ROUTE0..3 (4-bit line number per source, 8 sources per word).
// Build option: define SOPC_INTC_SYNC_EN to put a two-flop synchronizer on
//   src_i (source-to-int_o latency grows from 2 to 4 edges).
module sopc_intc #(
    parameter int NUM_SRC    = 8,
    parameter int NUM_OUT    = 6,
    parameter int ADDR_WIDTH = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    sopc_intc_if.slave         bus,
    output logic [NUM_OUT-1:0] int_o
);

    logic [NUM_SRC-1:0] src_s;

`ifdef SOPC_INTC_SYNC_EN
    logic [NUM_SRC-1:0] sync_q1;
    logic [NUM_SRC-1:0] sync_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= src_i;
            sync_q2 <= sync_q1;
        end
    end

    assign src_s = sync_q2;
`else
    assign src_s = src_i;
`endif

    logic [NUM_SRC-1:0] pend_r, mask_r, mode_r, src_d;
    logic [3:0]         route_r [NUM_SRC];

    logic               wr_en, rd_en;
    logic [3:0]         idx;
    logic [31:0]        lane;
    logic [31:0]        mask32, mode32, pend32, claim32, rd_data;
    logic [31:0]        mask_m32, mode_m32, w1c32;
    logic [31:0]        route_word [4];
    logic [NUM_SRC-1:0] mask_nxt, mode_nxt, pend_nxt, w1c, rise, active;
    logic [3:0]         route_nxt [NUM_SRC];
    logic [NUM_OUT-1:0] int_nxt;

    always_comb begin
        wr_en = bus.ce_i & bus.we_i;
        rd_en = bus.ce_i & ~bus.we_i;
        idx   = bus.addr_i[5:2];
        lane  = {{8{bus.sel_i[3]}}, {8{bus.sel_i[2]}}, {8{bus.sel_i[1]}}, {8{bus.sel_i[0]}}};

        mask32 = '0;
        mode32 = '0;
        pend32 = '0;
        mask32[NUM_SRC-1:0] = mask_r;
        mode32[NUM_SRC-1:0] = mode_r;
        pend32[NUM_SRC-1:0] = pend_r;

        // Lane-merged write data; bits at and above NUM_SRC fall away on slicing.
        mask_m32 = (mask32 & ~lane) | (bus.wdata_i & lane);
        mode_m32 = (mode32 & ~lane) | (bus.wdata_i & lane);
        w1c32    = (wr_en && idx == 4'd0) ? (bus.wdata_i & lane) : '0;

        mask_nxt = (wr_en && idx == 4'd1) ? mask_m32[NUM_SRC-1:0] : mask_r;
        mode_nxt = (wr_en && idx == 4'd2) ? mode_m32[NUM_SRC-1:0] : mode_r;
        w1c      = w1c32[NUM_SRC-1:0];
        rise     = src_s & ~src_d;

        // Pending follows the new mode so a MODE write takes effect at once:
        // leaving edge mode drops the latch, entering edge mode starts clear so
        // a source already high does not fire until it toggles.
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!mode_nxt[k])
                pend_nxt[k] = src_s[k];
            else if (mode_r[k])
                pend_nxt[k] = (pend_r[k] & ~w1c[k]) | rise[k];
            else
                pend_nxt[k] = rise[k];
        end

        for (int w = 0; w < 4; w++)
            route_word[w] = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            route_word[k / 8][4 * (k % 8) +: 4] = route_r[k];
            if (wr_en && idx == 4'(4 + k / 8) && bus.sel_i[(k % 8) / 2])
                route_nxt[k] = bus.wdata_i[4 * (k % 8) +: 4];
            else
                route_nxt[k] = route_r[k];
        end

        active = pend_r & mask_r;

        // Route values >= NUM_OUT never match a line index, so they are unrouted.
        int_nxt = '0;
        for (int j = 0; j < NUM_OUT; j++)
            for (int k = 0; k < NUM_SRC; k++)
                if (active[k] && route_r[k] == 4'(j))
                    int_nxt[j] = 1'b1;

        // Walk downward so the lowest-numbered active source wins.
        claim32 = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (active[k])
                claim32[4:0] = 5'(k);
        claim32[31] = |active;

        case (idx)
            4'd0:    rd_data = pend32;
            4'd1:    rd_data = mask32;
            4'd2:    rd_data = mode32;
            4'd3:    rd_data = claim32;
            4'd4:    rd_data = route_word[0];
            4'd5:    rd_data = route_word[1];
            4'd6:    rd_data = route_word[2];
            4'd7:    rd_data = route_word[3];
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r      <= '0;
            mask_r      <= '0;
            mode_r      <= '0;
            src_d       <= '0;
            int_o       <= '0;
            bus.rdata_o <= '0;
            for (int k = 0; k < NUM_SRC; k++)
                route_r[k] <= '0;
        end else begin
            pend_r <= pend_nxt;
            mask_r <= mask_nxt;
            mode_r <= mode_nxt;
            src_d  <= src_s;
            int_o  <= int_nxt;
            for (int k = 0; k < NUM_SRC; k++)
                route_r[k] <= route_nxt[k];
            if (rd_en)
                bus.rdata_o <= rd_data;
        end
    end

    logic unused;
    assign unused = ^{bus.addr_i, mask_m32, mode_m32, w1c32};

endmodule

// File: tb/tb_sopc_intc.sv
// tb/tb_sopc_intc.sv - scoreboard bench for sopc_intc
module tb_sopc_intc;

`ifdef SOPC_INTC_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    localparam logic [5:0] A_PEND  = 6'h00;
    localparam logic [5:0] A_MASK  = 6'h04;
    localparam logic [5:0] A_MODE  = 6'h08;
    localparam logic [5:0] A_CLAIM = 6'h0C;
    localparam logic [5:0] A_RT0   = 6'h10;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] src;
    logic [5:0] int_o;

    sopc_intc_if #(.ADDR_WIDTH(6)) bus ();

    sopc_intc #(.NUM_SRC(8), .NUM_OUT(6), .ADDR_WIDTH(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .src_i (src),
        .bus   (bus),
        .int_o (int_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_exp_q [$];
    string       rd_name_q [$];
    logic [5:0]  int_exp_q [$];
    string       int_name_q [$];
    logic        rd_vld = 1'b0;
    logic        int_probe = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A read registered at this edge means rdata_o carries its response.
    always @(posedge clk) rd_vld <= bus.ce_i & ~bus.we_i;

    always @(negedge clk) begin
        if (rd_vld) begin
            if (rd_exp_q.size() == 0) begin
                check("rd_queue_underflow", 32'd1, 32'd0);
            end else begin
                check(rd_name_q.pop_front(), bus.rdata_o, rd_exp_q.pop_front());
            end
        end
        if (int_probe) begin
            if (int_exp_q.size() == 0) begin
                check("int_queue_underflow", 32'd1, 32'd0);
            end else begin
                check(int_name_q.pop_front(), {26'd0, int_o}, {26'd0, int_exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] sel);
        bus.ce_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = addr;
        bus.wdata_i = data; bus.sel_i = sel;
        tick();
        bus.ce_i = 1'b0; bus.we_i = 1'b0;
    endtask

    task automatic rd(input logic [5:0] addr, input logic [31:0] exp, input string name);
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = addr;
        tick();
        bus.ce_i = 1'b0;
    endtask

    // Checks int_o as registered at the most recent edge.
    task automatic probe(input logic [5:0] exp, input string name);
        int_exp_q.push_back(exp);
        int_name_q.push_back(name);
        int_probe = 1'b1;
        @(negedge clk);
        #1;
        int_probe = 1'b0;
    endtask

    initial begin
        rst = 1'b1; src = '0;
        bus.ce_i = 1'b0; bus.we_i = 1'b0; bus.sel_i = 4'h0;
        bus.addr_i = '0; bus.wdata_i = '0;
        idle(3);
        rst = 1'b0;

        // Reset state
        for (int a = 0; a < 8; a++) rd(6'(a * 4), 32'h0, $sformatf("reset_reg_%0d", a));
        probe(6'h00, "reset_int");

        // Level source 0
        wr(A_MASK, 32'h1, 4'hF);
        src[0] = 1'b1;
        idle(LAT - 1);
        probe(6'h00, "lvl_rise_early");
        tick();
        probe(6'h01, "lvl_rise");
        rd(A_PEND, 32'h1, "lvl_pend");
        wr(A_PEND, 32'h1, 4'hF);
        rd(A_PEND, 32'h1, "lvl_w1c_ignored");
        src[0] = 1'b0;
        idle(LAT - 1);
        probe(6'h01, "lvl_fall_early");
        tick();
        probe(6'h00, "lvl_fall");
        rd(A_PEND, 32'h0, "lvl_pend_low");

        // Edge source 2 routed to line 3
        wr(A_MODE, 32'h4, 4'hF);
        wr(A_MASK, 32'h4, 4'hF);
        wr(A_RT0, 32'h0000_0300, 4'hF);
        src[2] = 1'b1;
        tick();
        src[2] = 1'b0;
        idle(LAT);
        probe(6'h08, "edge_fire");
        idle(3);
        probe(6'h08, "edge_hold");
        rd(A_CLAIM, 32'h8000_0002, "edge_claim");
        rd(A_RT0, 32'h0000_0300, "route0_rb");
        wr(A_PEND, 32'h4, 4'hF);
        probe(6'h08, "w1c_int_same_edge");
        tick();
        probe(6'h00, "w1c_int_drop");

        // W1C colliding with a new rising edge on source 1: set wins
        wr(A_MODE, 32'h6, 4'hF);
        src[1] = 1'b1;
        tick();
        src[1] = 1'b0;
        idle(LAT);
        rd(A_PEND, 32'h2, "edge1_pend");
        wr(A_PEND, 32'h2, 4'hF);
        rd(A_PEND, 32'h0, "edge1_cleared");
        src[1] = 1'b1;
        idle(LAT - 2);
        wr(A_PEND, 32'h2, 4'hF);
        rd(A_PEND, 32'h2, "set_wins");
        wr(A_PEND, 32'h2, 4'hF);
        rd(A_PEND, 32'h0, "held_high_no_refire");
        src[1] = 1'b0;
        tick();
        src[1] = 1'b1;
        tick();
        src[1] = 1'b0;
        idle(LAT);
        rd(A_PEND, 32'h2, "edge1_relatch");
        wr(A_MODE, 32'h4, 4'hF);
        rd(A_PEND, 32'h0, "edge_to_level_discard");

        // Sources 3 and 5 on line 1: claim priority
        wr(A_MODE, 32'h28, 4'hF);
        wr(A_MASK, 32'h28, 4'hF);
        wr(A_RT0, 32'h0010_1000, 4'hF);
        src[3] = 1'b1; src[5] = 1'b1;
        tick();
        src[3] = 1'b0; src[5] = 1'b0;
        idle(LAT);
        probe(6'h02, "two_src_line1");
        rd(A_CLAIM, 32'h8000_0003, "claim_3");
        wr(A_PEND, 32'h8, 4'hF);
        rd(A_CLAIM, 32'h8000_0005, "claim_5");
        probe(6'h02, "line1_still");
        rd(A_PEND, 32'h20, "pend_5_only");
        wr(A_MASK, 32'h0, 4'hF);
        probe(6'h02, "mask_same_edge");
        tick();
        probe(6'h00, "masked_off");
        rd(A_CLAIM, 32'h0, "claim_none");
        rd(A_PEND, 32'h20, "pend_unmasked");

        // Route value >= NUM_OUT is unrouted
        wr(A_RT0, 32'h0070_0000, 4'hF);
        wr(A_MASK, 32'h20, 4'hF);
        tick();
        probe(6'h00, "route7_unrouted");
        wr(A_RT0, 32'h0050_0000, 4'hF);
        probe(6'h00, "route_same_edge");
        tick();
        probe(6'h20, "route5");

        // Byte lanes, ce gating, unmapped addresses
        wr(A_MASK, 32'h0, 4'hF);
        wr(A_MASK, 32'hFFFF_FFFF, 4'b0001);
        rd(A_MASK, 32'hFF, "mask_lane0");
        wr(A_MASK, 32'h0, 4'b0010);
        rd(A_MASK, 32'hFF, "mask_lane1_only");
        bus.ce_i = 1'b0; bus.we_i = 1'b1; bus.addr_i = A_MASK;
        bus.wdata_i = 32'h0; bus.sel_i = 4'hF;
        tick();
        bus.we_i = 1'b0;
        rd(A_MASK, 32'hFF, "ce_low_write");
        wr(6'h24, 32'hFFFF_FFFF, 4'hF);
        rd(6'h24, 32'h0, "unmapped_24");
        rd(6'h20, 32'h0, "unmapped_20");
        rd(A_MODE, 32'h28, "mode_rb");

        // Mid-operation reset with source 4 held high
        src[4] = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(LAT);
        rd(A_PEND, 32'h10, "post_reset_pend");
        rd(A_MASK, 32'h0, "post_reset_mask");
        wr(A_MODE, 32'h10, 4'hF);
        rd(A_PEND, 32'h0, "edge_held_no_fire");
        wr(A_MASK, 32'h10, 4'hF);
        idle(LAT);
        probe(6'h00, "held_int_quiet");
        src[4] = 1'b0;
        tick();
        src[4] = 1'b1;
        idle(LAT);
        probe(6'h01, "retoggle_fires");
        rd(A_PEND, 32'h10, "retoggle_pend");

        idle(2);
        check("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
        check("int_queue_drained", 32'(int_exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sopc_intc.md
# sopc_intc

Parametrised, memory-mapped interrupt controller for the SOPC. It replaces the hard-wired `{5'b00000, timer_int}` concatenation with NUM_SRC maskable sources. Each source is level- or edge-triggered, and each is routed to one of NUM_OUT CPU interrupt lines. It sits on the core's data-memory bus beside the data RAM and drives the core's `int_i`.

## Interface
- NUM_SRC, 8: number of interrupt sources, 1..32.
- NUM_OUT, 6: width of `int_o`; must equal the core's `int_i` width, 1..16.
- ADDR_WIDTH, 6: decoded byte-address width; word index is `addr_i[5:2]`.

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- src_i  in  NUM_SRC  raw interrupt requests, active high
- ce_i  in  1  bus access strobe
- we_i  in  1  1 = write, 0 = read (qualified by ce_i)
- sel_i  in  4  byte-lane enables for writes
- addr_i  in  ADDR_WIDTH  byte address
- wdata_i  in  32  write data
- rdata_o  out  32  read data, registered
- int_o  out  NUM_OUT  interrupt lines to the core, registered

## Operation
- Register map (word offsets), 32-bit; bits at and above NUM_SRC read 0 and ignore writes:
  - 0x00 PENDING: RO for level sources; write-1-to-clear for edge sources.
  - 0x04 MASK: RW; 1 = enabled.
  - 0x08 MODE: RW; 1 = edge, 0 = level.
  - 0x0C CLAIM: RO. bit31 = any pending&mask; bits[4:0] = lowest-numbered pending&enabled source; 0 when none. Reading CLAIM does not clear anything.
  - 0x10..0x1C ROUTE0..3: RW. 4-bit field per source, 8 sources per word; source k is at ROUTEk/8, bits [4*(k%8)+3 : 4*(k%8)].
- Routing and outputs:
  - Route values >= NUM_OUT are treated as "not routed".
  - `int_o[j]` = OR over k of (pending[k] & mask[k] & route[k]==j).
- Level source: pending[k] = registered src sample. PENDING writes have no effect.
- Edge source:
  - Sampled src 0->1 sets pending[k]; pending stays set until W1C.
  - If a set and a W1C happen on the same edge, set wins.
  - Switching MODE edge->level discards the latched bit; pending then follows level.
- Mask affects only `int_o` and CLAIM. PENDING shows unmasked state.
- Bus access:
  - Writes honour sel_i byte lanes.
  - Unmapped writes are ignored; unmapped reads return 0.
  - A write with ce_i=0 has no effect.
- Reset values: PENDING 0, MASK 0, MODE 0, ROUTE all 0 (all sources routed to line 0), edge-history registers 0, rdata_o 0, int_o 0.
- A reset mid-operation clears latched edge pending immediately. After reset, a source held high and configured as edge does not fire until it goes low, then high again.

## Timing
- Read: ce_i=1, we_i=0 at edge E; rdata_o is valid after E and held until the next read.
- Write: takes effect at edge E, and is visible to a read issued at E+1.
- Source to output, without sync: src_i sampled high at edge E; pending updates at E; int_o updates at E+1. Latency is 2 edges.
- Mask/route write at E changes int_o at E+1.
- W1C at E: pending clears at E, int_o drops at E+1.
- Back-to-back bus accesses are allowed every cycle. There are no wait states.

## Configuration
- `SOPC_INTC_SYNC_EN` defined:
  - src_i passes through a two-flop synchronizer, reset to 0, before level sampling and edge detection.
  - Source-to-int_o latency becomes 4 edges.
  - Required for asynchronous or off-chip sources.
- Not defined: src_i is assumed synchronous to clk and is sampled directly.

## Test plan
- Reset then read all registers -> every read returns 0x00000000; int_o == 0.
- MODE=0, MASK=0x01, src_i[0] held high -> int_o[0]=1 two edges after src rises (four with SYNC_EN). src low -> int_o[0]=0 after the same latency. PENDING writes are ignored.
- MODE=0x04, MASK=0x04, ROUTE0=0x00000300, pulse src_i[2] for one cycle -> int_o[3]=1 and stays 1. CLAIM=0x80000002. Write PENDING=0x04 -> int_o[3]=0 one edge later.
- Edge source 1: W1C on the same edge as a new rising edge -> PENDING bit 1 remains 1.
- Sources 5 and 3 pending and enabled, both routed to line 1 -> int_o[1]=1; CLAIM=0x80000003. After clearing 3, CLAIM=0x80000005.
- Write MASK=0xFFFFFFFF with sel_i=4'b0001, NUM_SRC=8 -> MASK reads 0x000000FF. A write to 0x24 is ignored and reads back 0.
